// File: rtl/tbus_mem_responder_if.sv
// rtl/tbus_mem_responder_if.sv - request/response bundle between a tbus initiator and the memory responder
interface tbus_mem_responder_if;
  logic        tbus_index_valid;
  logic        tbus_index_ready;
  logic [63:0] tbus_index;
  logic [63:0] tbus_write_data;
  logic [63:0] tbus_write_mask;
  logic [1:0]  tbus_operation_type;
  logic [63:0] tbus_read_data;
  logic        tbus_operation_done;
  logic        tbus_access_err;

  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done, tbus_access_err
  );

  modport slave (
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done, tbus_access_err
  );
endinterface

// File: rtl/tbus_mem_responder.sv
// rtl/tbus_mem_responder.sv - fixed-latency 64-bit word memory responder on the tbus request bus
// Optional address range checking is enabled by defining TBUS_RESP_BOUNDS_CHECK_EN.
module tbus_mem_responder #(
  parameter int          DEPTH     = 512,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input logic                 clock,
  input logic                 reset,
  tbus_mem_responder_if.slave tbus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [3:0]    count;
  logic          ready_q;
  logic          done_q;
  logic [63:0]   rdata_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic [63:0]   mask_q;
  logic [1:0]    op_q;
  logic          oob_q;

  logic [63:0]   mem [DEPTH];

  logic          accept;
  logic [AW-1:0] req_idx;
  logic          req_oob;

  assign accept  = tbus.tbus_index_valid && ready_q;
  assign req_idx = AW'((tbus.tbus_index - BASE_ADDR) >> 3);

`ifdef TBUS_RESP_BOUNDS_CHECK_EN
  // Any offset bit above the word index means the request lies past the top of storage.
  assign req_oob = (tbus.tbus_index < BASE_ADDR) ||
                   (((tbus.tbus_index - BASE_ADDR) >> (3 + AW)) != 64'd0);
  assign tbus.tbus_access_err = done_q & oob_q;
`else
  assign req_oob = 1'b0;
  assign tbus.tbus_access_err = 1'b0;
`endif

  assign tbus.tbus_index_ready    = ready_q;
  assign tbus.tbus_operation_done = done_q;
  assign tbus.tbus_read_data      = rdata_q;

  function automatic logic [63:0] resp(input logic [1:0] op, input logic oob, input logic [63:0] word);
    if (oob) return '1;
    if (op == OP_READ || op == OP_WRITE) return word;
    return '0;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 4'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 64'd0;
      idx_q   <= '0;
      wdata_q <= 64'd0;
      mask_q  <= 64'd0;
      op_q    <= OP_READ;
      oob_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= tbus.tbus_write_data;
            mask_q  <= tbus.tbus_write_mask;
            op_q    <= tbus.tbus_operation_type;
            oob_q   <= req_oob;
            ready_q <= 1'b0;
            // Single-cycle latency has no BUSY phase, so respond from the live request.
            if (LATENCY == 1) begin
              state   <= DONE;
              done_q  <= 1'b1;
              rdata_q <= resp(tbus.tbus_operation_type, req_oob, mem[req_idx]);
            end else begin
              state <= BUSY;
              count <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (count == 4'd0) begin
            state   <= DONE;
            done_q  <= 1'b1;
            rdata_q <= resp(op_q, oob_q, mem[idx_q]);
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage is never reset; an aborted request never reaches DONE, so it never writes.
  always_ff @(posedge clock) begin
    if (state == DONE && op_q == OP_WRITE && !oob_q) begin
      mem[idx_q] <= (mem[idx_q] & ~mask_q) | (wdata_q & mask_q);
    end
  end
endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb/tb_tbus_mem_responder.sv - self-checking bench for tbus_mem_responder
module tb_tbus_mem_responder;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  tbus_mem_responder_if bus ();
  tbus_mem_responder_if bus1 ();

  tbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .tbus(bus));
  tbus_mem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clock(clock), .reset(reset), .tbus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [63:0] model_mem [DEPTH];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mask;
    logic [1:0]  op;
    bit          chk_rd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] mask,
                          input logic [1:0] op, output logic [63:0] rd, output logic err);
    logic [63:0] off;
    int unsigned idx;
    logic        oob;
    off = addr - BASE;
    idx = int'((off >> 3) % DEPTH);
    oob = 1'b0;
`ifdef TBUS_RESP_BOUNDS_CHECK_EN
    oob = (addr < BASE) || (off >= 64'(8 * DEPTH));
`endif
    err = oob;
    if (oob) rd = '1;
    else if (op == 2'b00 || op == 2'b01) rd = model_mem[idx];
    else rd = '0;
    if (op == 2'b01 && !oob) model_mem[idx] = (model_mem[idx] & ~mask) | (wd & mask);
  endtask

  // Called at a negedge with the responder idle; returns at a negedge with it idle again.
  task automatic do_op(input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] mask,
                       input logic [1:0] op, output logic [63:0] rd, output logic err);
    int  waited;
    int  j;
    bit  got;
    bus.tbus_index_valid    = 1'b1;
    bus.tbus_index          = addr;
    bus.tbus_write_data     = wd;
    bus.tbus_write_mask     = mask;
    bus.tbus_operation_type = op;
    waited = 0;
    while (!bus.tbus_index_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.tbus_index_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.tbus_index_valid = 1'b0;
      rd  = '0;
      err = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    bus.tbus_index_valid = 1'b0;
    j   = 0;
    got = 0;
    while (j < 20) begin
      if (bus.tbus_operation_done) begin
        got = 1;
        break;
      end
      @(negedge clock);
      j++;
    end
    chk("latency", got ? 64'(j) : 64'd99, 64'(LAT - 1));
    rd  = bus.tbus_read_data;
    err = bus.tbus_access_err;
    chk("ready_in_done", 64'(bus.tbus_index_ready), 64'd0);
    @(negedge clock);
    chk("done_pulse", 64'(bus.tbus_operation_done), 64'd0);
    chk("err_pulse", 64'(bus.tbus_access_err), 64'd0);
    chk("ready_after", 64'(bus.tbus_index_ready), 64'd1);
    chk("rdata_hold", bus.tbus_read_data, rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic [63:0] exp_rd;
    logic        err;
    logic        exp_err;
    logic [63:0] addr;
    int          mode;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.tbus_index_valid     = 1'b0;
    bus.tbus_index           = '0;
    bus.tbus_write_data      = '0;
    bus.tbus_write_mask      = '0;
    bus.tbus_operation_type  = 2'b00;
    bus1.tbus_index_valid    = 1'b0;
    bus1.tbus_index          = '0;
    bus1.tbus_write_data     = '0;
    bus1.tbus_write_mask     = '0;
    bus1.tbus_operation_type = 2'b00;

    vecs[0]  = '{BASE + 64'h10, 64'h1122_3344_5566_7788, '1, 2'b01, 0, '0, 1'b0};
    vecs[1]  = '{BASE + 64'h10, '0, '0, 2'b00, 1, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{BASE + 64'h10, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0000_0000_FFFF_FFFF, 2'b01, 1,
                 64'h1122_3344_5566_7788, 1'b0};
    vecs[3]  = '{BASE + 64'h10, '0, '0, 2'b00, 1, 64'h1122_3344_BBBB_BBBB, 1'b0};
    vecs[4]  = '{BASE + 64'h17, '0, '0, 2'b00, 1, 64'h1122_3344_BBBB_BBBB, 1'b0};
    vecs[5]  = '{BASE + 64'h08, 64'hDEAD_BEEF_0123_4567, '1, 2'b01, 0, '0, 1'b0};
    vecs[6]  = '{BASE + 64'h08, 64'h5555_5555_5555_5555, '1, 2'b11, 1, '0, 1'b0};
    vecs[7]  = '{BASE + 64'h08, '0, '0, 2'b00, 1, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[8]  = '{BASE, 64'h0F0F_1234_F0F0_5678, '1, 2'b01, 0, '0, 1'b0};
`ifdef TBUS_RESP_BOUNDS_CHECK_EN
    vecs[9]  = '{BASE + 64'h1000, '0, '0, 2'b00, 1, '1, 1'b1};
`else
    vecs[9]  = '{BASE + 64'h1000, '0, '0, 2'b00, 1, 64'h0F0F_1234_F0F0_5678, 1'b0};
`endif
    vecs[10] = '{BASE + 64'h10, '0, '0, 2'b10, 1, '0, 1'b0};
    vecs[11] = '{BASE + 64'h10, '1, '0, 2'b01, 1, 64'h1122_3344_BBBB_BBBB, 1'b0};
    vecs[12] = '{BASE + 64'h10, '0, '0, 2'b00, 1, 64'h1122_3344_BBBB_BBBB, 1'b0};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 64'(bus.tbus_index_ready), 64'd1);
    chk("rst_done", 64'(bus.tbus_operation_done), 64'd0);
    chk("rst_err", 64'(bus.tbus_access_err), 64'd0);
    chk("rst_rdata", bus.tbus_read_data, 64'd0);
    chk("rst_ready1", 64'(bus1.tbus_index_ready), 64'd1);
    chk("rst_rdata1", bus1.tbus_read_data, 64'd0);

    // Fill every word so the model is fully known.
    for (int i = 0; i < DEPTH; i++) begin
      addr = BASE + 64'(i * 8);
      do_op(addr, {$urandom, $urandom}, '1, 2'b01, rd, err);
      model_op(addr, rd, '1, 2'b00, exp_rd, exp_err);
      model_mem[i] = bus.tbus_write_data;
    end

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].op, rd, err);
      model_op(vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].op, exp_rd, exp_err);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
    end

    // Reset during the BUSY cycle of a write aborts it.
    bus.tbus_index_valid    = 1'b1;
    bus.tbus_index          = BASE + 64'h20;
    bus.tbus_write_data     = 64'hCAFE_F00D_CAFE_F00D;
    bus.tbus_write_mask     = '1;
    bus.tbus_operation_type = 2'b01;
    @(posedge clock);
    @(negedge clock);
    bus.tbus_index_valid = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      chk($sformatf("abort_done_%0d", j), 64'(bus.tbus_operation_done), 64'd0);
    end
    chk("abort_ready", 64'(bus.tbus_index_ready), 64'd1);
    chk("abort_rdata", bus.tbus_read_data, 64'd0);
    do_op(BASE + 64'h20, '0, '0, 2'b00, rd, err);
    model_op(BASE + 64'h20, '0, '0, 2'b00, exp_rd, exp_err);
    chk("abort_word", rd, exp_rd);

    // LATENCY=1 responder with valid held: done every other cycle, ready low while done.
    bus1.tbus_index_valid    = 1'b1;
    bus1.tbus_index          = BASE;
    bus1.tbus_operation_type = 2'b00;
    @(posedge clock);
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      chk($sformatf("l1_done_%0d", j), 64'(bus1.tbus_operation_done), 64'(j % 2 == 0));
      chk($sformatf("l1_ready_%0d", j), 64'(bus1.tbus_index_ready), 64'(j % 2 == 1));
    end
    bus1.tbus_index_valid = 1'b0;
    repeat (2) @(negedge clock);

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      mode = int'($urandom_range(0, 9));
      if (mode <= 6)      addr = BASE + 64'($urandom_range(0, DEPTH - 1) * 8) + 64'($urandom_range(0, 7));
      else if (mode == 7) addr = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, DEPTH - 1) * 8);
      else if (mode == 8) addr = BASE - 64'($urandom_range(1, 64) * 8);
      else                addr = BASE + 64'h1_0000_0000 + 64'($urandom_range(0, DEPTH - 1) * 8);
      exp_rd = {$urandom, $urandom};
      do_op(addr, exp_rd, {$urandom, $urandom}, 2'($urandom_range(0, 3)), rd, err);
      model_op(addr, bus.tbus_write_data, bus.tbus_write_mask, bus.tbus_operation_type, exp_rd, exp_err);
      chk($sformatf("rand%0d_rdata@%h", i, addr), rd, exp_rd);
      chk($sformatf("rand%0d_err", i), 64'(err), 64'(exp_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tbus_mem_responder.md
TBUS_MEM_RESPONDER -- requirements
Module: tbus_mem_responder

Interface
REQ-001 Parameter DEPTH, default 512, is the number of 64-bit words of backing storage; it SHALL be a power of two, minimum 2.
REQ-002 Parameter LATENCY, default 2, is the number of cycles from request acceptance to operation_done; legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 64'h8000_0000, is the byte address of word 0.
REQ-004 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tbus_index_valid  input  1  initiator request valid.
REQ-007 tbus_index_ready  output  1  responder can accept a request.
REQ-008 tbus_index  input  64  request byte address.
REQ-009 tbus_write_data  input  64  store data.
REQ-010 tbus_write_mask  input  64  per-bit write enable; 1 means write the bit.
REQ-011 tbus_operation_type  input  2  2'b00 read, 2'b01 write, 2'b10/2'b11 reserved.
REQ-012 tbus_read_data  output  64  read result.
REQ-013 tbus_operation_done  output  1  single-cycle completion pulse.
REQ-014 tbus_access_err  output  1  single-cycle out-of-range pulse, coincident with done.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; tbus_index_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur in a cycle where valid and ready are both 1; address, data, mask and type SHALL be captured that edge.
REQ-017 On acceptance: LATENCY=1 -> DONE; otherwise -> BUSY with a down-counter loaded to LATENCY-2.
REQ-018 BUSY SHALL go to DONE when the counter is 0, otherwise decrement.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE; tbus_operation_done SHALL be 1 only in DONE.
REQ-020 For acceptance at edge T, done SHALL be high in cycle T+LATENCY; the next acceptance can occur no earlier than edge T+LATENCY+1.
REQ-021 Word index SHALL be (tbus_index - BASE_ADDR) >> 3, using the low log2(DEPTH) bits; byte-offset bits [2:0] SHALL be ignored.
REQ-022 Read: tbus_read_data SHALL present the word contents during the DONE cycle.
REQ-023 Write: the word SHALL become (old & ~mask) | (wdata & mask), committed at the DONE-exit edge; tbus_read_data SHALL show the pre-write word.
REQ-024 Reserved types SHALL complete with normal timing, leave memory unchanged, and return read_data 0.
REQ-025 tbus_read_data SHALL hold its value from DONE until the next DONE.
REQ-026 tbus_index_valid while not ready SHALL be ignored; the initiator holds the request.
REQ-027 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-028 Reset asserted SHALL force state IDLE, counter 0, tbus_index_ready 1 after deassertion, tbus_operation_done 0, tbus_access_err 0, tbus_read_data 0.
REQ-029 Reset asserted mid-operation SHALL abort the request: no done pulse, and no memory write for it.

Configuration
REQ-030 Macro TBUS_RESP_BOUNDS_CHECK_EN, when defined: an address below BASE_ADDR or at/above BASE_ADDR+8*DEPTH SHALL complete with normal timing, return read_data 64'hFFFF_FFFF_FFFF_FFFF, drop any write, and pulse tbus_access_err with done.
REQ-031 When undefined: the address SHALL wrap modulo DEPTH words per REQ-021, and tbus_access_err SHALL be tied 0.

Verification
REQ-032 LATENCY=2: write 0x8000_0010 data 64'h1122_3344_5566_7788, mask all-ones accepted at T -> done at T+2, ready again at T+3; read 0x8000_0010 -> 64'h1122_3344_5566_7788.
REQ-033 Partial write: mask 64'h0000_0000_FFFF_FFFF, data 64'hAAAA_AAAA_BBBB_BBBB over 64'h1122_3344_5566_7788 -> readback 64'h1122_3344_BBBB_BBBB.
REQ-034 LATENCY=1: valid held high, 3 back-to-back reads -> done at T+1, T+3 and T+5; ready low in each done cycle.
REQ-035 Reset pulsed in the BUSY cycle of a write to 0x8000_0020 -> no done, word unchanged on a later read.
REQ-036 With TBUS_RESP_BOUNDS_CHECK_EN, DEPTH=512: read 0x8000_1000 -> done with read_data all-ones and access_err=1. Without it: the same read returns word 0, access_err=0.
REQ-037 Type 2'b11 write-style request to 0x8000_0008 -> done at T+LATENCY, read_data 0, word 1 unchanged.
